// File: rtl/obi_mem_arbiter_2to1.sv
// Two-master OBI arbiter sharing one memory port: round-robin address phase,
// selection held until granted, responses routed in issue order through an ID FIFO.
module obi_mem_arbiter_2to1 #(
    parameter int AW              = 64,
    parameter int DW              = 64,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               i_req_i,
    output logic                               i_gnt_o,
    input  logic [AW-1:0]                      i_addr_i,
    input  logic                               i_we_i,
    input  logic [DW/8-1:0]                    i_be_i,
    input  logic [DW-1:0]                      i_wdata_i,
    output logic                               i_rvalid_o,
    output logic [DW-1:0]                      i_rdata_o,
    input  logic                               d_req_i,
    output logic                               d_gnt_o,
    input  logic [AW-1:0]                      d_addr_i,
    input  logic                               d_we_i,
    input  logic [DW/8-1:0]                    d_be_i,
    input  logic [DW-1:0]                      d_wdata_i,
    output logic                               d_rvalid_o,
    output logic [DW-1:0]                      d_rdata_o,
    output logic                               m_req_o,
    input  logic                               m_gnt_i,
    output logic [AW-1:0]                      m_addr_o,
    output logic                               m_we_o,
    output logic [DW/8-1:0]                    m_be_o,
    output logic [DW-1:0]                      m_wdata_o,
    input  logic                               m_rvalid_i,
    input  logic [DW-1:0]                      m_rdata_i,
    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_o,
    output logic                               err_o
);
    localparam int PW = $clog2(MAX_OUTSTANDING);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);
    localparam logic SIDE_I = 1'b0;
    localparam logic SIDE_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD_I = 2'd1,
        HOLD_D = 2'd2
    } state_t;

    state_t                     state_r;
    state_t                     state_next_s;
    logic                       rr_last_r;
    logic [MAX_OUTSTANDING-1:0] id_fifo_r;
    logic [PW-1:0]              wptr_r;
    logic [PW-1:0]              rptr_r;
    logic [CW-1:0]              count_r;
    logic                       err_r;

    logic sel_s;
    logic sel_req_s;
    logic not_full_s;
    logic req_s;
    logic hs_s;
    logic head_s;
    logic pop_s;
    logic stray_s;
    logic drop_s;

    // Pick the master that owns the address phase this cycle.
    always_comb begin
        sel_s = SIDE_D;
        case (state_r)
            HOLD_I: sel_s = SIDE_I;
            HOLD_D: sel_s = SIDE_D;
            IDLE: begin
                if (i_req_i && d_req_i) begin
                    sel_s = ~rr_last_r;
                end else if (i_req_i) begin
                    sel_s = SIDE_I;
                end else begin
                    sel_s = SIDE_D;
                end
            end
            default: sel_s = SIDE_D;
        endcase
    end

    // Outputs are forced quiet while reset is asserted, not just after the next edge.
    assign sel_req_s  = (sel_s == SIDE_D) ? d_req_i : i_req_i;
    assign not_full_s = (count_r < MAX_CNT);
    assign req_s      = rst_ni & sel_req_s & not_full_s;
    assign hs_s       = req_s & m_gnt_i;
    assign head_s     = id_fifo_r[rptr_r];
    assign pop_s      = rst_ni & m_rvalid_i & (count_r != {CW{1'b0}});
    assign stray_s    = m_rvalid_i & (count_r == {CW{1'b0}});
    assign drop_s     = ((state_r == HOLD_I) && !i_req_i) || ((state_r == HOLD_D) && !d_req_i);

    assign m_req_o   = req_s;
    assign m_addr_o  = req_s ? ((sel_s == SIDE_D) ? d_addr_i  : i_addr_i)  : {AW{1'b0}};
    assign m_we_o    = req_s ? ((sel_s == SIDE_D) ? d_we_i    : i_we_i)    : 1'b0;
    assign m_be_o    = req_s ? ((sel_s == SIDE_D) ? d_be_i    : i_be_i)    : {(DW/8){1'b0}};
    assign m_wdata_o = req_s ? ((sel_s == SIDE_D) ? d_wdata_i : i_wdata_i) : {DW{1'b0}};

    assign i_gnt_o    = hs_s & (sel_s == SIDE_I);
    assign d_gnt_o    = hs_s & (sel_s == SIDE_D);
    assign i_rvalid_o = pop_s & (head_s == SIDE_I);
    assign d_rvalid_o = pop_s & (head_s == SIDE_D);
    assign i_rdata_o  = i_rvalid_o ? m_rdata_i : {DW{1'b0}};
    assign d_rdata_o  = d_rvalid_o ? m_rdata_i : {DW{1'b0}};

    assign outstanding_o = count_r;
    assign err_o         = err_r;

    // Next state: lock the selection while its request waits for a grant.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_s && !m_gnt_i) begin
                    state_next_s = (sel_s == SIDE_D) ? HOLD_D : HOLD_I;
                end else begin
                    state_next_s = IDLE;
                end
            end
            HOLD_I, HOLD_D: begin
                if (drop_s || hs_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = state_r;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State register, round-robin history and sticky protocol error.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r   <= IDLE;
            rr_last_r <= SIDE_I;
            err_r     <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if (hs_s) begin
                rr_last_r <= sel_s;
            end
            if (drop_s || stray_s) begin
                err_r <= 1'b1;
            end
        end
    end

    // ID FIFO recording which master issued each granted request.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            id_fifo_r <= {MAX_OUTSTANDING{1'b0}};
            wptr_r    <= {PW{1'b0}};
            rptr_r    <= {PW{1'b0}};
            count_r   <= {CW{1'b0}};
        end else begin
            if (hs_s) begin
                id_fifo_r[wptr_r] <= sel_s;
                wptr_r            <= wptr_r + PW'(1);
            end
            if (pop_s) begin
                rptr_r <= rptr_r + PW'(1);
            end
            case ({hs_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

// File: tb/tb_obi_mem_arbiter_2to1.sv
// Bench for obi_mem_arbiter_2to1: vector table, directed corner sequences and a
// randomized run checked against a queue-based reference model.
module tb_obi_mem_arbiter_2to1;
    localparam int AW   = 64;
    localparam int DW   = 64;
    localparam int MAXO = 8;
    localparam int CW   = $clog2(MAXO) + 1;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b1;
    logic          i_req = 1'b0, i_gnt, i_we = 1'b0, i_rvalid;
    logic [AW-1:0] i_addr = '0;
    logic [7:0]    i_be = '0;
    logic [DW-1:0] i_wdata = '0, i_rdata;
    logic          d_req = 1'b0, d_gnt, d_we = 1'b0, d_rvalid;
    logic [AW-1:0] d_addr = '0;
    logic [7:0]    d_be = '0;
    logic [DW-1:0] d_wdata = '0, d_rdata;
    logic          m_req, m_gnt = 1'b0, m_we, m_rvalid = 1'b0;
    logic [AW-1:0] m_addr;
    logic [7:0]    m_be;
    logic [DW-1:0] m_wdata, m_rdata = '0;
    logic [CW-1:0] outstanding;
    logic          err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    obi_mem_arbiter_2to1 #(.AW(AW), .DW(DW), .MAX_OUTSTANDING(MAXO)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .i_req_i(i_req), .i_gnt_o(i_gnt), .i_addr_i(i_addr), .i_we_i(i_we), .i_be_i(i_be),
        .i_wdata_i(i_wdata), .i_rvalid_o(i_rvalid), .i_rdata_o(i_rdata),
        .d_req_i(d_req), .d_gnt_o(d_gnt), .d_addr_i(d_addr), .d_we_i(d_we), .d_be_i(d_be),
        .d_wdata_i(d_wdata), .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata),
        .m_req_o(m_req), .m_gnt_i(m_gnt), .m_addr_o(m_addr), .m_we_o(m_we), .m_be_o(m_be),
        .m_wdata_o(m_wdata), .m_rvalid_i(m_rvalid), .m_rdata_i(m_rdata),
        .outstanding_o(outstanding), .err_o(err)
    );

    typedef struct {
        logic        ir, dr, g, rv;
        logic        e_ig, e_dg, e_mreq, e_irv, e_drv, e_err;
        logic [63:0] e_addr;
        int          e_out;
    } vec_t;
    vec_t tbl[$];

    // Reference model: in-flight IDs as a queue, locked master, round-robin history.
    bit q[$];
    bit rr_m;
    int lock_m;
    bit err_m;
    bit ig_prev, dg_prev;

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [3:0] in, input logic [5:0] ex, input logic [63:0] a, input int o);
        vec_t v;
        {v.ir, v.dr, v.g, v.rv} = in;
        {v.e_ig, v.e_dg, v.e_mreq, v.e_irv, v.e_drv, v.e_err} = ex;
        v.e_addr = a;
        v.e_out  = o;
        tbl.push_back(v);
    endtask

    task automatic go(input logic [3:0] in);
        {i_req, d_req, m_gnt, m_rvalid} = in;
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        {i_req, d_req, m_gnt, m_rvalid} = 4'b0000;
        rst_ni = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        q.delete();
        rr_m    = 1'b0;
        lock_m  = -1;
        err_m   = 1'b0;
        ig_prev = 1'b0;
        dg_prev = 1'b0;
    endtask

    task automatic rnd_cycle();
        bit sel, sreq, mreq, pop, hd;
        if (lock_m >= 0) sel = (lock_m == 1);
        else if (i_req && d_req) sel = !rr_m;
        else sel = d_req;
        sreq = sel ? d_req : i_req;
        mreq = sreq && (q.size() < MAXO);
        pop  = m_rvalid && (q.size() > 0);
        hd   = pop ? q[0] : 1'b0;
        @(negedge clk);
        chk1("r_m_req", m_req, mreq);
        chk1("r_i_gnt", i_gnt, mreq && m_gnt && !sel);
        chk1("r_d_gnt", d_gnt, mreq && m_gnt && sel);
        chk64("r_m_addr", m_addr, mreq ? (sel ? d_addr : i_addr) : 64'h0);
        chk64("r_m_wdata", m_wdata, mreq ? (sel ? d_wdata : i_wdata) : 64'h0);
        chk64("r_m_we_be", 64'({m_we, m_be}), mreq ? 64'(sel ? {d_we, d_be} : {i_we, i_be}) : 64'h0);
        chk1("r_i_rvalid", i_rvalid, pop && !hd);
        chk1("r_d_rvalid", d_rvalid, pop && hd);
        chk64("r_i_rdata", i_rdata, (pop && !hd) ? m_rdata : 64'h0);
        chk64("r_d_rdata", d_rdata, (pop && hd) ? m_rdata : 64'h0);
        chk64("r_outstanding", 64'(outstanding), 64'(q.size()));
        chk1("r_err", err, err_m);
        ig_prev = mreq && m_gnt && !sel;
        dg_prev = mreq && m_gnt && sel;
        @(posedge clk);
        if (lock_m >= 0 && !((lock_m == 1) ? d_req : i_req)) begin
            err_m  = 1'b1;
            lock_m = -1;
        end else if (mreq && m_gnt) begin
            lock_m = -1;
        end else if (mreq && lock_m < 0) begin
            lock_m = sel ? 1 : 0;
        end
        if (m_rvalid) begin
            if (q.size() > 0) void'(q.pop_front());
            else err_m = 1'b1;
        end
        if (mreq && m_gnt) begin
            q.push_back(sel);
            rr_m = sel;
        end
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        // inputs {i_req,d_req,m_gnt,m_rvalid}; expect {i_gnt,d_gnt,m_req,i_rvalid,d_rvalid,err}
        add_vec(4'b1010, 6'b101000, 64'h1000, 0);
        add_vec(4'b0000, 6'b000000, 64'h0,    1);
        add_vec(4'b0001, 6'b000100, 64'h0,    1);
        add_vec(4'b1110, 6'b011000, 64'h2000, 0);
        add_vec(4'b1110, 6'b101000, 64'h1000, 1);
        add_vec(4'b1110, 6'b011000, 64'h2000, 2);
        add_vec(4'b1111, 6'b101010, 64'h1000, 3);
        add_vec(4'b0001, 6'b000100, 64'h0,    3);
        add_vec(4'b0001, 6'b000010, 64'h0,    2);
        add_vec(4'b0001, 6'b000100, 64'h0,    1);
        add_vec(4'b0001, 6'b000000, 64'h0,    0);
        add_vec(4'b0000, 6'b000001, 64'h0,    0);

        #1;
        do_reset();
        i_addr = 64'h1000; d_addr = 64'h2000; i_be = 8'hFF; d_be = 8'hFF;
        m_rdata = 64'hDEAD_BEEF;
        go(4'b0000);
        chk1("rst_m_req", m_req, 1'b0);
        chk64("rst_outstanding", 64'(outstanding), 64'h0);
        chk1("rst_err", err, 1'b0);
        tick();

        for (int k = 0; k < tbl.size(); k++) begin
            v = tbl[k];
            go({v.ir, v.dr, v.g, v.rv});
            chk1($sformatf("t%0d_i_gnt", k), i_gnt, v.e_ig);
            chk1($sformatf("t%0d_d_gnt", k), d_gnt, v.e_dg);
            chk1($sformatf("t%0d_m_req", k), m_req, v.e_mreq);
            chk1($sformatf("t%0d_i_rvalid", k), i_rvalid, v.e_irv);
            chk1($sformatf("t%0d_d_rvalid", k), d_rvalid, v.e_drv);
            chk1($sformatf("t%0d_err", k), err, v.e_err);
            chk64($sformatf("t%0d_m_addr", k), m_addr, v.e_addr);
            chk64($sformatf("t%0d_i_rdata", k), i_rdata, v.e_irv ? 64'hDEAD_BEEF : 64'h0);
            chk64($sformatf("t%0d_d_rdata", k), d_rdata, v.e_drv ? 64'hDEAD_BEEF : 64'h0);
            chk64($sformatf("t%0d_outstanding", k), 64'(outstanding), 64'(v.e_out));
            tick();
        end

        // D held without grant for three cycles while I also requests
        do_reset();
        d_addr = 64'h100;
        for (int k = 0; k < 3; k++) begin
            i_addr = {$urandom, $urandom};
            go(4'b1100);
            chk64($sformatf("hold%0d_m_addr", k), m_addr, 64'h100);
            chk1($sformatf("hold%0d_d_gnt", k), d_gnt, 1'b0);
            chk1($sformatf("hold%0d_i_gnt", k), i_gnt, 1'b0);
            tick();
        end
        go(4'b1110);
        chk1("hold3_d_gnt", d_gnt, 1'b1);
        chk1("hold3_i_gnt", i_gnt, 1'b0);
        chk64("hold3_m_addr", m_addr, 64'h100);
        tick();
        i_addr = 64'h1000;
        go(4'b1010);
        chk1("hold4_i_gnt", i_gnt, 1'b1);
        chk64("hold4_m_addr", m_addr, 64'h1000);
        tick();

        // fill to MAX_OUTSTANDING, then drain one and refill
        do_reset();
        for (int k = 0; k < MAXO; k++) begin
            go(4'b1010);
            chk1($sformatf("fill%0d_i_gnt", k), i_gnt, 1'b1);
            chk64($sformatf("fill%0d_outstanding", k), 64'(outstanding), 64'(k));
            tick();
        end
        go(4'b1010);
        chk1("full_m_req", m_req, 1'b0);
        chk1("full_i_gnt", i_gnt, 1'b0);
        chk64("full_outstanding", 64'(outstanding), 64'(MAXO));
        tick();
        go(4'b1011);
        chk1("full_pop_m_req", m_req, 1'b0);
        chk1("full_pop_i_rvalid", i_rvalid, 1'b1);
        tick();
        go(4'b1011);
        chk1("pushpop_i_gnt", i_gnt, 1'b1);
        chk1("pushpop_i_rvalid", i_rvalid, 1'b1);
        chk64("pushpop_outstanding", 64'(outstanding), 64'(MAXO - 1));
        tick();
        go(4'b1010);
        chk64("after_pushpop_outstanding", 64'(outstanding), 64'(MAXO - 1));
        chk1("refill_i_gnt", i_gnt, 1'b1);
        tick();
        go(4'b0000);
        chk64("refill_outstanding", 64'(outstanding), 64'(MAXO));
        tick();

        // request dropped while held, then async reset with three in flight
        do_reset();
        go(4'b1000);
        chk1("drop_m_req", m_req, 1'b1);
        tick();
        go(4'b0000);
        tick();
        go(4'b0000);
        chk1("drop_err", err, 1'b1);
        tick();
        for (int k = 0; k < 3; k++) begin
            go(4'b0110);
            tick();
        end
        {i_req, d_req, m_gnt, m_rvalid} = 4'b1111;
        #2;
        rst_ni = 1'b0;
        #1;
        chk64("arst_outstanding", 64'(outstanding), 64'h0);
        chk1("arst_err", err, 1'b0);
        chk1("arst_m_req", m_req, 1'b0);
        chk1("arst_gnt", i_gnt | d_gnt, 1'b0);
        chk1("arst_rvalid", i_rvalid | d_rvalid, 1'b0);
        tick();
        rst_ni = 1'b1;
        go(4'b1110);
        chk1("arst_tie_d_gnt", d_gnt, 1'b1);
        chk1("arst_tie_i_gnt", i_gnt, 1'b0);
        tick();

        // randomized traffic against the reference model
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            if (i_req && !ig_prev) begin
                if ($urandom_range(0, 49) == 0) i_req = 1'b0;
            end else begin
                i_req   = ($urandom_range(0, 2) != 0);
                i_addr  = {$urandom, $urandom};
                i_we    = 1'($urandom);
                i_be    = 8'($urandom);
                i_wdata = {$urandom, $urandom};
            end
            if (d_req && !dg_prev) begin
                if ($urandom_range(0, 49) == 0) d_req = 1'b0;
            end else begin
                d_req   = ($urandom_range(0, 2) != 0);
                d_addr  = {$urandom, $urandom};
                d_we    = 1'($urandom);
                d_be    = 8'($urandom);
                d_wdata = {$urandom, $urandom};
            end
            m_gnt    = 1'($urandom);
            m_rvalid = ($urandom_range(0, 2) == 0);
            m_rdata  = {$urandom, $urandom};
            rnd_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
